// File: rtl/serial_unsigned_subtractor.sv
// ---------------------------------------------------------------------------
// serial_unsigned_subtractor
//
// Multi-cycle unsigned subtract-with-borrow. Computes {bo, D} = A - B - bi
// over N/W clock steps, W bits per step, least-significant slice first.
// It is the area-lean companion of the combinational unsigned adder and keeps
// the same operand/carry conventions (A/B/bi in, D/bo out).
//
// Parameters
//   N     operand and result width in bits
//   W     bits processed per step (1 <= W <= N, N % W == 0)
//
// Ports
//   clk    in   rising-edge clock
//   rst    in   synchronous, active-high reset (beats start on the same edge)
//   start  in   request an operation; honoured only in IDLE or DONE
//   A      in   minuend, captured on the accepted start edge
//   B      in   subtrahend, captured on the accepted start edge
//   bi     in   borrow-in, captured on the accepted start edge
//   busy   out  high while the operation is stepping (RUN)
//   done   out  one-cycle pulse when D/bo have just been updated
//   D      out  difference (A - B - bi) mod 2^N, held until next completion
//   bo     out  borrow-out, 1 iff A < B + bi, held until next completion
// ---------------------------------------------------------------------------
module serial_unsigned_subtractor #(
    parameter int N = 8,
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         bi,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] D,
    output logic         bo
);

    if (W < 1 || W > N || (N % W) != 0) begin : g_bad_params
        $error("serial_unsigned_subtractor: W must satisfy 1 <= W <= N and N %% W == 0");
    end

    localparam int STEPS = N / W;
    // Keep the counter at least one bit wide even for the single-step case.
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [N-1:0]     a_q,     a_d;
    logic [N-1:0]     b_q,     b_d;
    logic [N-1:0]     res_q,   res_d;
    logic             brw_q,   brw_d;
    logic [N-1:0]     d_q,     d_d;
    logic             bo_q,    bo_d;

    logic [W:0]       step_diff;
    logic [N+W-1:0]   a_ext;
    logic [N+W-1:0]   b_ext;
    logic [N+W-1:0]   res_ext;
    logic [N-1:0]     res_next;
    logic             load;

    always_comb begin
        // One slice of the subtraction: the MSB of the (W+1)-bit result is
        // set exactly when the slice underflowed, i.e. it is the next borrow.
        step_diff = {1'b0, a_q[W-1:0]} - {1'b0, b_q[W-1:0]} - {{W{1'b0}}, brw_q};

        // Right shifts written as slices of a zero-extended copy so that the
        // W == N case (shift out everything) needs no special handling.
        a_ext    = {{W{1'b0}}, a_q};
        b_ext    = {{W{1'b0}}, b_q};
        // New slice enters at the top; after N/W steps the first slice has
        // walked down to bit 0 and the register holds the full difference.
        res_ext  = {step_diff[W-1:0], res_q};
        res_next = res_ext[N+W-1:W];

        load = start && ((state_q == S_IDLE) || (state_q == S_DONE));

        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        brw_d   = brw_q;
        d_d     = d_q;
        bo_d    = bo_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                a_d   = a_ext[N+W-1:W];
                b_d   = b_ext[N+W-1:W];
                res_d = res_next;
                brw_d = step_diff[W];
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_STEP) begin
                    // Publish straight from the shifted value so the last
                    // slice is included on this same edge.
                    state_d = S_DONE;
                    d_d     = res_next;
                    bo_d    = step_diff[W];
                end
            end
            S_DONE: begin
                state_d = start ? S_RUN : S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Fresh capture; the incoming borrow seeds the running borrow.
        if (load) begin
            a_d   = A;
            b_d   = B;
            brw_d = bi;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            brw_q   <= 1'b0;
            d_q     <= '0;
            bo_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            brw_q   <= brw_d;
            d_q     <= d_d;
            bo_q    <= bo_d;
        end
    end

    // Status decoded from the state flop only; no input reaches an output
    // without passing through a register.
    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_DONE);
    assign D    = d_q;
    assign bo   = bo_q;

endmodule

// File: tb/tb_serial_unsigned_subtractor.sv
// ---------------------------------------------------------------------------
// tb_serial_unsigned_subtractor
//
// Drives three instances (N=8 with W=1, 4, 8) from shared operand inputs and
// per-instance start lines, and compares every completion against a plain
// arithmetic reference of A - B - bi.
// ---------------------------------------------------------------------------
module tb_serial_unsigned_subtractor;

    logic       clk;
    logic       rst;
    logic [2:0] start_v;
    logic [7:0] a;
    logic [7:0] b;
    logic       bi;

    logic       busy_o [3];
    logic       done_o [3];
    logic [7:0] d_o    [3];
    logic       bo_o   [3];

    int n_checks;
    int n_fails;

    localparam int STEPS [3] = '{8, 2, 1};

    serial_unsigned_subtractor #(.N(8), .W(1)) u_w1 (
        .clk(clk), .rst(rst), .start(start_v[0]), .A(a), .B(b), .bi(bi),
        .busy(busy_o[0]), .done(done_o[0]), .D(d_o[0]), .bo(bo_o[0])
    );
    serial_unsigned_subtractor #(.N(8), .W(4)) u_w4 (
        .clk(clk), .rst(rst), .start(start_v[1]), .A(a), .B(b), .bi(bi),
        .busy(busy_o[1]), .done(done_o[1]), .D(d_o[1]), .bo(bo_o[1])
    );
    serial_unsigned_subtractor #(.N(8), .W(8)) u_w8 (
        .clk(clk), .rst(rst), .start(start_v[2]), .A(a), .B(b), .bi(bi),
        .busy(busy_o[2]), .done(done_o[2]), .D(d_o[2]), .bo(bo_o[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Reference: the 9-bit two's-complement wrap of A - B - bi.
    function automatic logic [8:0] ref_sub(input logic [7:0] av, input logic [7:0] bv, input logic biv);
        int diff;
        diff = int'(av) - int'(bv) - int'(biv);
        return 9'(diff);
    endfunction

    // Start all three instances together and watch them for 10 cycles.
    task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input logic biv,
                          input bit scramble);
        logic [8:0] exp;
        int lat [3];
        int nd  [3];
        exp = ref_sub(av, bv, biv);
        for (int i = 0; i < 3; i++) begin
            lat[i] = 0;
            nd[i]  = 0;
        end
        @(negedge clk);
        a = av; b = bv; bi = biv; start_v = 3'b111;
        @(posedge clk);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            start_v = 3'b000;
            if (scramble) begin
                a  = 8'($urandom);
                b  = 8'($urandom);
                bi = 1'($urandom);
            end
            @(posedge clk);
            #1;
            for (int i = 0; i < 3; i++) begin
                if (k < STEPS[i])  check_val($sformatf("busy_run_w%0d", i), 32'(busy_o[i]), 32'd1);
                if (k == STEPS[i]) check_val($sformatf("busy_done_w%0d", i), 32'(busy_o[i]), 32'd0);
                if (done_o[i] === 1'b1) begin
                    nd[i]++;
                    if (lat[i] == 0) begin
                        lat[i] = k;
                        check_val($sformatf("D_w%0d", i), 32'(d_o[i]), 32'(exp[7:0]));
                        check_val($sformatf("bo_w%0d", i), 32'(bo_o[i]), 32'(exp[8]));
                        check_val($sformatf("ident_w%0d", i),
                                  32'(d_o[i]) + 32'(bv) + 32'(biv),
                                  32'(av) + (32'(bo_o[i]) << 8));
                    end
                end else if (lat[i] != 0) begin
                    check_val($sformatf("D_hold_w%0d", i), 32'(d_o[i]), 32'(exp[7:0]));
                    check_val($sformatf("bo_hold_w%0d", i), 32'(bo_o[i]), 32'(exp[8]));
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            check_val($sformatf("latency_w%0d", i), 32'(lat[i]), 32'(STEPS[i]));
            check_val($sformatf("done_count_w%0d", i), 32'(nd[i]), 32'd1);
        end
    endtask

    initial begin
        int lat;
        int nd;
        int lat2;
        n_checks = 0;
        n_fails  = 0;
        rst = 1'b1; start_v = 3'b000; a = 8'd0; b = 8'd0; bi = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check_val("rst_busy", 32'(busy_o[i]), 32'd0);
            check_val("rst_done", 32'(done_o[i]), 32'd0);
            check_val("rst_D",    32'(d_o[i]),    32'd0);
            check_val("rst_bo",   32'(bo_o[i]),   32'd0);
        end
        @(negedge clk);
        rst = 1'b0;

        // Directed arithmetic cases, including underflow and borrow-in.
        run_op(8'd15,  8'd10,  1'b0, 1'b0);
        run_op(8'd5,   8'd10,  1'b0, 1'b0);
        run_op(8'd0,   8'd0,   1'b1, 1'b0);
        run_op(8'd255, 8'd255, 1'b0, 1'b0);
        run_op(8'd10,  8'd5,   1'b1, 1'b0);
        run_op(8'd0,   8'd255, 1'b1, 1'b0);

        // start pulsed 3 cycles into RUN must be ignored (W=1 instance).
        lat = 0; nd = 0;
        @(negedge clk);
        a = 8'd20; b = 8'd3; bi = 1'b0; start_v = 3'b001;
        @(posedge clk);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            start_v = (k == 3) ? 3'b001 : 3'b000;
            if (k == 3) begin a = 8'd1; b = 8'd2; bi = 1'b1; end
            @(posedge clk);
            #1;
            if (done_o[0] === 1'b1) begin
                nd++;
                if (lat == 0) begin
                    lat = k;
                    check_val("ign_D",  32'(d_o[0]),  32'd17);
                    check_val("ign_bo", 32'(bo_o[0]), 32'd0);
                end
            end
        end
        check_val("ign_latency", 32'(lat), 32'd8);
        check_val("ign_done_count", 32'(nd), 32'd1);

        // start held high through DONE: immediate restart.
        lat = 0; lat2 = 0; nd = 0;
        @(negedge clk);
        a = 8'd100; b = 8'd1; bi = 1'b0; start_v = 3'b001;
        @(posedge clk);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 18) start_v = 3'b000;
            @(posedge clk);
            #1;
            if (k == 9) check_val("b2b_busy_restart", 32'(busy_o[0]), 32'd1);
            if (done_o[0] === 1'b1) begin
                nd++;
                if (lat == 0) lat = k; else if (lat2 == 0) lat2 = k;
                check_val("b2b_D", 32'(d_o[0]), 32'd99);
                check_val("b2b_bo", 32'(bo_o[0]), 32'd0);
            end
        end
        start_v = 3'b000;
        check_val("b2b_first_latency", 32'(lat), 32'd8);
        check_val("b2b_second_latency", 32'(lat2), 32'd17);

        // Reset in the middle of 200 - 50.
        @(negedge clk);
        a = 8'd200; b = 8'd50; bi = 1'b0; start_v = 3'b001;
        @(posedge clk);
        @(negedge clk);
        start_v = 3'b000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_val("mid_rst_busy", 32'(busy_o[0]), 32'd0);
        check_val("mid_rst_done", 32'(done_o[0]), 32'd0);
        check_val("mid_rst_D",    32'(d_o[0]),    32'd0);
        check_val("mid_rst_bo",   32'(bo_o[0]),   32'd0);
        @(negedge clk);
        rst = 1'b0;
        nd = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done_o[0] === 1'b1) nd++;
        end
        check_val("mid_rst_no_done", 32'(nd), 32'd0);
        run_op(8'd200, 8'd50, 1'b0, 1'b0);

        // Operand inputs churn during RUN.
        run_op(8'd77, 8'd200, 1'b1, 1'b1);

        // Random regression on all three configurations.
        for (int r = 0; r < 20; r++) begin
            run_op(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
